// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the select of an N_CH-to-1 mux through the enabled
// channels, dwells DWELL cycles on each, captures the mux output, and presents
// one bit per channel as a parallel word with a one-cycle valid pulse per frame.
module mux_scan_sequencer #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [N_CH-1:0]   sample,
    output logic              valid
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    // DONE is the frame-end decision; it is resolved on the final capture edge,
    // so the register only lands there if corrupted, and then recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [SEL_W-1:0]    sel_nx;
    logic                busy_nx;
    logic                valid_nx;
    logic [N_CH-1:0]     sample_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [N_CH-1:0]     mask, mask_nx;
    logic [N_CH-1:0]     shadow, shadow_nx;
    logic [N_CH-1:0]     captured;
    logic [SEL_W:0]      next_ch;

    // Lowest enabled channel index in a mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur; MSB flags that one exists.
    function automatic logic [SEL_W:0] next_above(input logic [N_CH-1:0] m,
                                                  input logic [SEL_W-1:0] cur);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

    // Next-state and next-output decode for the scan controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_nx  = state;
        sel_nx    = sel;
        busy_nx   = busy;
        valid_nx  = 1'b0;
        sample_nx = sample;
        cnt_nx    = cnt;
        mask_nx   = mask;
        shadow_nx = shadow;
        captured  = shadow;
        captured[sel] = mux_out;
        next_ch   = next_above(mask, sel);

        case (state)
            IDLE: begin
                if (start && (ch_mask != '0)) begin
                    mask_nx   = ch_mask;
                    sel_nx    = lowest_ch(ch_mask);
                    cnt_nx    = '0;
                    shadow_nx = '0;
                    busy_nx   = 1'b1;
                    state_nx  = SCAN;
                end
            end
            SCAN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx    = '0;
                    shadow_nx = captured;
                    if (next_ch[SEL_W]) begin
                        sel_nx = next_ch[SEL_W-1:0];
                    end else begin
                        // Final capture: publish the frame and decide what follows.
                        sample_nx = captured;
                        valid_nx  = 1'b1;
                        if (cont && (ch_mask != '0)) begin
                            mask_nx   = ch_mask;
                            sel_nx    = lowest_ch(ch_mask);
                            shadow_nx = '0;
                            state_nx  = SCAN;
                        end else begin
                            busy_nx  = 1'b0;
                            state_nx = IDLE;
                        end
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            sample <= '0;
            cnt    <= '0;
            mask   <= '0;
            shadow <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the pre-edge values.
            state  <= state_nx;
            sel    <= sel_nx;
            busy   <= busy_nx;
            valid  <= valid_nx;
            sample <= sample_nx;
            cnt    <= cnt_nx;
            mask   <= mask_nx;
            shadow <= shadow_nx;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: one instance with DWELL=4 for single
// frames, reset and masking; one with DWELL=1 for continuous mode. Expected
// values come from the enabled-channel list and data & mask per frame.
module tb_mux_scan_sequencer;

    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DWELL=4 instance
    logic       start4, cont4, mux4, busy4, valid4;
    logic [3:0] mask4, data4, sample4;
    logic [1:0] sel4;
    assign mux4 = data4[sel4];

    // DWELL=1 instance
    logic       start1, cont1, mux1, busy1, valid1;
    logic [3:0] mask1, data1, sample1;
    logic [1:0] sel1;
    assign mux1 = data1[sel1];

    mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(DWELL)) u_d4 (
        .clk(clk), .rst(rst), .start(start4), .cont(cont4), .ch_mask(mask4),
        .mux_out(mux4), .sel(sel4), .busy(busy4), .sample(sample4), .valid(valid4)
    );

    mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .cont(cont1), .ch_mask(mask1),
        .mux_out(mux1), .sel(sel1), .busy(busy1), .sample(sample1), .valid(valid1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on the DWELL=4 instance; optionally pokes start and ch_mask mid-frame.
    task automatic do_frame(input logic [3:0] m, input logic [3:0] d, input bit poke, input string tag);
        int ch[$];
        int k;
        for (int i = 0; i < 4; i++) if (m[i]) ch.push_back(i);
        k = ch.size();
        mask4  = m;
        data4  = d;
        start4 = 1'b1;
        tick();                       // edge T0
        start4 = 1'b0;
        for (int j = 0; j < k; j++) begin
            for (int c = 0; c < DWELL; c++) begin
                check({tag, ".sel"},   32'(sel4),   32'(ch[j]));
                check({tag, ".busy"},  32'(busy4),  32'd1);
                check({tag, ".valid"}, 32'(valid4), 32'd0);
                start4 = poke && (j == k - 1) && (c == 1);
                if (start4) mask4 = 4'($urandom);
                tick();
            end
        end
        // just after edge T0 + k*DWELL
        check({tag, ".valid_end"},  32'(valid4),  32'd1);
        check({tag, ".sample"},     32'(sample4), 32'(d & m));
        check({tag, ".busy_end"},   32'(busy4),   32'd0);
        check({tag, ".sel_hold"},   32'(sel4),    32'(ch[k-1]));
        tick();
        check({tag, ".valid_once"}, 32'(valid4),  32'd0);
        check({tag, ".sample_hold"},32'(sample4), 32'(d & m));
        check({tag, ".idle_busy"},  32'(busy4),   32'd0);
    endtask

    initial begin
        logic [3:0] fd [3];
        logic [3:0] rm, rd;

        rst = 1'b1;
        start4 = 1'b0; cont4 = 1'b0; mask4 = '0; data4 = '0;
        start1 = 1'b0; cont1 = 1'b0; mask1 = '0; data1 = '0;
        tick();
        tick();
        check("reset.sel",    32'(sel4),    32'd0);
        check("reset.busy",   32'(busy4),   32'd0);
        check("reset.valid",  32'(valid4),  32'd0);
        check("reset.sample", 32'(sample4), 32'd0);
        rst = 1'b0;
        tick();

        // Full frame, all channels enabled.
        do_frame(4'b1111, 4'b1010, 1'b0, "full");
        // Masked frame with a stray start and mask change mid-frame.
        do_frame(4'b0101, 4'b1111, 1'b1, "masked");

        // Asynchronous reset in the middle of a scan.
        mask4 = 4'b1111; data4 = 4'b0110; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (5) tick();
        check("pre_rst.busy", 32'(busy4), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_async.sel",    32'(sel4),    32'd0);
        check("rst_async.busy",   32'(busy4),   32'd0);
        check("rst_async.valid",  32'(valid4),  32'd0);
        check("rst_async.sample", 32'(sample4), 32'd0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            check("post_rst.valid", 32'(valid4), 32'd0);
            check("post_rst.busy",  32'(busy4),  32'd0);
            tick();
        end

        // Start with an empty mask is ignored.
        mask4 = 4'b0000; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int t = 0; t < 4 * DWELL + 2; t++) begin
            check("zero_mask.busy",  32'(busy4),  32'd0);
            check("zero_mask.valid", 32'(valid4), 32'd0);
            tick();
        end

        // Randomized frames.
        for (int n = 0; n < 8; n++) begin
            rm = 4'($urandom_range(1, 15));
            rd = 4'($urandom);
            do_frame(rm, rd, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        // Continuous mode, DWELL=1: back-to-back frames every 4 cycles.
        fd[0] = 4'b0011;
        fd[1] = 4'b1100;
        fd[2] = 4'($urandom);
        cont1 = 1'b1; mask1 = 4'b1111; data1 = fd[0]; start1 = 1'b1;
        tick();                       // edge T0
        start1 = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            check($sformatf("cont.sel%0d", t),   32'(sel1),   (t == 12) ? 32'd3 : 32'(t % 4));
            check($sformatf("cont.busy%0d", t),  32'(busy1),  (t < 12) ? 32'd1 : 32'd0);
            check($sformatf("cont.valid%0d", t), 32'(valid1), (t > 0 && t % 4 == 0) ? 32'd1 : 32'd0);
            if (t > 0 && t % 4 == 0)
                check($sformatf("cont.sample%0d", t), 32'(sample1), 32'(fd[t/4 - 1]));
            if (t == 4) data1 = fd[1];
            if (t == 8) begin
                data1 = fd[2];
                cont1 = 1'b0;
            end
            tick();
        end
        check("cont.end_valid", 32'(valid1),  32'd0);
        check("cont.end_busy",  32'(busy1),   32'd0);
        check("cont.end_sel",   32'(sel1),    32'd3);
        check("cont.end_sample",32'(sample1), 32'(fd[2]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequential controller that drives the select lines of the 4-to-1 mux and captures its single-bit output.
- Steps SEL through the enabled channels, dwells a programmable number of cycles on each so the mux output settles, then samples it.
- Assembles one bit per channel into a parallel word and flags each completed frame with a one-cycle valid pulse.
- Sits between the control logic, which requests a scan, and the mux datapath, which it feeds and consumes.

Parameters:
- N_CH, 4, number of mux channels scanned.
- SEL_W, 2, width of the select bus; must satisfy 2**SEL_W >= N_CH.
- DWELL, 4, clock cycles spent on each channel before sampling; must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one frame; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at each frame end.
- ch_mask  input  N_CH  channel enable mask; bit i=1 scans channel i; latched at start.
- mux_out  input  1  output of the mux under control.
- sel  output  SEL_W  registered select driven to the mux.
- busy  output  1  high while a frame is in progress.
- sample  output  N_CH  last completed frame; bit i = captured mux_out of channel i.
- valid  output  1  one-cycle pulse when sample updates.

Behaviour:
- Reset (async, rst=1): state=IDLE; sel=0, busy=0, valid=0, sample=0; dwell counter=0; latched mask=0; shadow register=0. Outputs hold these values while rst is high. Reset mid-frame aborts the frame with no valid pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 with ch_mask!=0 at edge T0: latch ch_mask; sel=lowest enabled index; counter=0; shadow=0; busy=1; go to SCAN.
  - start=1 with ch_mask==0: ignored; stay in IDLE with busy=0.
- SCAN:
  - Counter increments every cycle.
  - When counter==DWELL-1, the edge writes mux_out into shadow[sel] and resets the counter.
  - At that same edge, sel advances to the next enabled index above the current one. If no enabled index remains, go to DONE instead.
  - Masked channels are never selected, and their sample bits read 0.
- Timing for a frame with k enabled channels:
  - Capture edges fall at T0+DWELL, T0+2*DWELL, ..., T0+k*DWELL.
  - The last capture edge loads sample (shadow including the final bit) and asserts valid for exactly one cycle.
- Frame end (the DONE transition is taken on the final capture edge, with no extra cycle):
  - cont=0: busy=0 and state=IDLE at that edge; sel holds its last value.
  - cont=1: relatch ch_mask and begin the next frame at the same edge. sel goes to the lowest enabled index, busy stays 1, and the pipeline has no gap.
  - cont=1 with new ch_mask==0: end as if cont=0.
- start while busy: ignored. ch_mask changes mid-frame: ignored.
- DWELL=1: sel advances every cycle and samples on every edge.
- Counter width: clog2(DWELL)+1 bits. Wrap from DWELL-1 to 0 only.
- sel is glitch-free, since it is a registered output. mux_out is assumed combinational from sel, so the value sampled has settled for DWELL cycles.

Test Plan:
- Reset: assert rst mid-SCAN with DWELL=4 -> sel=0, busy=0, valid=0, sample=0 immediately, without waiting for a clock edge; no valid pulse afterwards.
- Single full frame: ch_mask=4'b1111, mux_out modelled as I=4'b1010 through sel, start pulse -> sel steps 0,1,2,3 every 4 cycles; valid at T0+16; sample=4'b1010; busy low at the same edge.
- Masked frame: ch_mask=4'b0101, I=4'b1111 -> sel visits 0 then 2 only; valid at T0+8; sample=4'b0101.
- Zero mask and busy start: start with ch_mask=0 -> busy stays 0 and no valid. Second start pulse mid-frame -> frame timing unchanged, exactly one valid.
- Continuous mode: cont=1, ch_mask=4'b1111, DWELL=1 -> valid every 4 cycles with no gap and busy constant 1. Drop cont -> the current frame completes, then busy=0.
- Data change between frames: I changes from 4'b0011 to 4'b1100 between two continuous frames -> successive sample values are 4'b0011 then 4'b1100.
